// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running binary counter: locks on, counts wraps, flags breaks.
// Optional feature: define COUNT_CHK_DOWN_EN to track a down-counter instead of an up-counter.
module count_seq_checker #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [WIDTH-1:0] expected,
    output logic [7:0]       wrap_cnt,
    output logic [7:0]       err_cnt
);

    localparam int unsigned MW = 4;
    localparam int unsigned CW = 8;
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [CW-1:0]    CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [MW-1:0]    match_q, match_d;
    logic             locked_d, err_d, sticky_d;
    logic [WIDTH-1:0] exp_d;
    logic [CW-1:0]    wrap_d, errc_d;
    logic             step_ok_c, wrap_evt_c;

    // Predicted successor of a sample in the tracked counting direction
    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
`ifdef COUNT_CHK_DOWN_EN
        return x - WIDTH'(1);
`else
        return x + WIDTH'(1);
`endif
    endfunction

    assign step_ok_c = (count_in == nxt(last_q));
`ifdef COUNT_CHK_DOWN_EN
    assign wrap_evt_c = (last_q == '0) && (count_in == MAX_VAL);
`else
    assign wrap_evt_c = (last_q == MAX_VAL) && (count_in == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= '0;
            match_q    <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            expected   <= '0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            match_q    <= match_d;
            locked     <= locked_d;
            err        <= err_d;
            err_sticky <= sticky_d;
            expected   <= exp_d;
            wrap_cnt   <= wrap_d;
            err_cnt    <= errc_d;
        end
    end

    // Next-state and registered-output values; everything holds without a valid sample
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        match_d  = match_q;
        locked_d = locked;
        err_d    = 1'b0;
        sticky_d = err_sticky;
        exp_d    = expected;
        wrap_d   = wrap_cnt;
        errc_d   = err_cnt;

        if (in_valid) begin
            last_d = count_in;
            exp_d  = nxt(count_in);
            unique case (state_q)
                IDLE: begin
                    match_d = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (step_ok_c) begin
                        match_d = match_q + MW'(1);
                        if (match_d == MW'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (step_ok_c) begin
                        if (wrap_evt_c && (wrap_cnt != CNT_MAX)) begin
                            wrap_d = wrap_cnt + CW'(1);
                        end
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        if (err_cnt != CNT_MAX) begin
                            errc_d = err_cnt + CW'(1);
                        end
                        locked_d = 1'b0;
                        match_d  = '0;
                        state_d  = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: a spec-level model predicts outputs per cycle,
// a monitor compares them after each rising edge. Honours COUNT_CHK_DOWN_EN like the DUT.
module tb_count_seq_checker;

    localparam int unsigned WIDTH    = 3;
    localparam int unsigned LOCK_CNT = 2;
    localparam int          M        = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic             locked, err, err_sticky;
    logic [WIDTH-1:0] expected;
    logic [7:0]       wrap_cnt, err_cnt;

    count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
        .locked(locked), .err(err), .err_sticky(err_sticky), .expected(expected),
        .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lck; int e; int stk; int ex; int wr; int ec;
    } resp_t;

    resp_t q[$];
    int errors = 0;
    int checks = 0;

    // Spec-level model state: phase 0=waiting for first sample, 1=acquiring, 2=locked
    int phase = 0, last = 0, run = 0;
    int m_lck = 0, m_err = 0, m_stk = 0, m_exp = 0, m_wrap = 0, m_errc = 0;

    function automatic int succ(input int x);
`ifdef COUNT_CHK_DOWN_EN
        return (x + M - 1) % M;
`else
        return (x + 1) % M;
`endif
    endfunction

    // A correct step that wraps moves "backwards" numerically in the counting direction
    function automatic bit crosses(input int from, input int to);
`ifdef COUNT_CHK_DOWN_EN
        return to > from;
`else
        return to < from;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input int d);
        m_err = 0;
        if (r) begin
            phase = 0; last = 0; run = 0;
            m_lck = 0; m_stk = 0; m_exp = 0; m_wrap = 0; m_errc = 0;
        end else if (v) begin
            if (phase == 0) begin
                run = 0; phase = 1;
            end else if (phase == 1) begin
                if (d == succ(last)) begin
                    run++;
                    if (run == LOCK_CNT) begin phase = 2; m_lck = 1; end
                end else run = 0;
            end else begin
                if (d == succ(last)) begin
                    if (crosses(last, d) && m_wrap < 255) m_wrap++;
                end else begin
                    m_err = 1; m_stk = 1;
                    if (m_errc < 255) m_errc++;
                    m_lck = 0; run = 0; phase = 1;
                end
            end
            last  = d;
            m_exp = succ(d);
        end
    endtask

    task automatic drive(input bit r, input bit v, input int d);
        resp_t s;
        @(negedge clk);
        rst = r; in_valid = v; count_in = WIDTH'(d);
        model(r, v, d);
        s.lck = m_lck; s.e = m_err; s.stk = m_stk; s.ex = m_exp; s.wr = m_wrap; s.ec = m_errc;
        q.push_back(s);
    endtask

    // Feed n samples continuing the tracked sequence from `start`
    task automatic run_seq(input int start, input int n);
        int v = start;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, v);
            v = succ(v);
        end
    endtask

    // Monitor: one response per rising edge that followed a drive
    initial begin
        resp_t s;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                s = q.pop_front();
                check("locked", int'(locked), s.lck);
                check("err", int'(err), s.e);
                check("err_sticky", int'(err_sticky), s.stk);
                check("expected", int'(expected), s.ex);
                check("wrap_cnt", int'(wrap_cnt), s.wr);
                check("err_cnt", int'(err_cnt), s.ec);
            end
        end
    end

    initial begin
        int start, v;
        // Reset with a valid sample present
        drive(1'b1, 1'b1, 5);
        drive(1'b1, 1'b1, 5);
`ifdef COUNT_CHK_DOWN_EN
        start = 2;
`else
        start = 5;
`endif
        // Lock, then two wraps
        run_seq(start, 3 + M + 1);
        // Bring expected to start+? then break with a wrong value and relock
        run_seq(m_exp, 2);
        drive(1'b0, 1'b1, (m_exp + 2) % M);
        run_seq(m_exp, 2);
        // Valid gaps with random data on the bus
        run_seq(m_exp, 4);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, $urandom_range(M - 1));
        run_seq(m_exp, 1);
        // Reset mid-lock together with a wrong valid sample
        run_seq(m_exp, M);
        drive(1'b1, 1'b1, (m_exp + 3) % M);
        drive(1'b0, 1'b0, 0);
        // Repeated value while locked is an error
        run_seq(1, 4);
        drive(1'b0, 1'b1, last);
        // err_cnt saturation: repeated lock/break cycles
        for (int i = 0; i < 270; i++) begin
            run_seq(m_exp, LOCK_CNT);
            drive(1'b0, 1'b1, (m_exp + 1 + int'($urandom_range(M - 2))) % M);
        end
        // wrap_cnt saturation: long clean run
        run_seq(m_exp, 3);
        run_seq(m_exp, 260 * M);
        // Random mix of gaps, good steps, bad values and rare resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) drive(1'b1, $urandom_range(1), $urandom_range(M - 1));
            else begin
                v = ($urandom_range(99) < 85) ? m_exp : int'($urandom_range(M - 1));
                drive(1'b0, ($urandom_range(99) < 80), v);
            end
        end
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
